// File: rtl/control_unit_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_multicycle_if
// Description : Interface between the multi-cycle control unit and the
//               datapath / shared memory port. The control unit takes the
//               master view; the datapath and memory take the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_multicycle_if #(
    parameter int ALUOP_W = 3
);
    // Datapath / memory -> control unit
    logic [6:0]         opcode;
    logic               sys_bit;
    logic               branch_taken;
    logic               mem_ready;

    // Control unit -> datapath / memory
    logic               mem_req;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic [2:0]         imm_src;
    logic               reg_write;
    logic [1:0]         wb_sel;
    logic               trap;
    logic [1:0]         trap_cause;
    logic               halted;
    logic [2:0]         state;

    modport master (
        input  opcode, sys_bit, branch_taken, mem_ready,
        output mem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
               branch, alu_op, alu_src, imm_src, reg_write, wb_sel,
               trap, trap_cause, halted, state
    );

    modport slave (
        output opcode, sys_bit, branch_taken, mem_ready,
        input  mem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
               branch, alu_op, alu_src, imm_src, reg_write, wb_sel,
               trap, trap_cause, halted, state
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_multicycle
// Description : Multi-cycle main control FSM. Sequences FETCH/DECODE/EXEC/
//               MEM/WB over one shared req/ready memory port with a wait
//               timeout, decodes RV32 major opcodes and handles illegal
//               opcodes, ecall/ebreak traps, bus-error traps and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_multicycle #(
    parameter int ALUOP_W        = 3,
    parameter int MEM_TIMEOUT    = 16,
    parameter int HALT_ON_EBREAK = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    control_unit_multicycle_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_SYSTEM  = 2'b10;
    localparam logic [1:0] c_CAUSE_BUS     = 2'b11;

    // Last wait count before the limit; a miss at this count trips the timeout
    localparam logic [7:0] c_TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [6:0] r_opcode;
    logic       r_sys_bit;
    logic [1:0] r_cause;

    logic [6:0] w_op;
    logic [2:0] w_aop;
    logic [2:0] w_imm;
    logic       w_asrc;
    logic       w_legal;
    logic       w_sys;
    logic       w_load;
    logic       w_store;
    logic       w_br;
    logic       w_jump;

    logic       w_timeout;
    logic       w_set_cause;
    logic [1:0] w_cause_next;
    logic       w_dec_en;
    logic       w_req, w_rd, w_wr, w_irw, w_pcw, w_pcs, w_brs, w_rw, w_trap;
    logic [1:0] w_wb;

    // In DECODE the live IR is decoded; from EXEC on the captured copy is used
    assign w_op      = (r_state == S_DECODE) ? bus.opcode : r_opcode;
    assign w_timeout = !bus.mem_ready && (r_cnt == c_TO_LAST);

    // Opcode decode into ALU class, immediate format and instruction kind
    always_comb begin
        w_aop   = 3'b000;
        w_imm   = 3'b000;
        w_asrc  = 1'b0;
        w_legal = 1'b1;
        w_sys   = 1'b0;
        w_load  = 1'b0;
        w_store = 1'b0;
        w_br    = 1'b0;
        w_jump  = 1'b0;
        case (w_op)
            c_OP_R:      w_aop = 3'b000;
            c_OP_I:      begin w_aop = 3'b001; w_asrc = 1'b1; end
            c_OP_JALR:   begin w_aop = 3'b001; w_asrc = 1'b1; w_jump = 1'b1; end
            c_OP_LOAD:   begin w_aop = 3'b010; w_asrc = 1'b1; w_load = 1'b1; end
            c_OP_STORE:  begin w_aop = 3'b011; w_asrc = 1'b1; w_imm = 3'b001; w_store = 1'b1; end
            c_OP_BRANCH: begin w_aop = 3'b100; w_imm = 3'b010; w_br = 1'b1; end
            c_OP_JAL:    begin w_aop = 3'b101; w_imm = 3'b011; w_jump = 1'b1; end
            c_OP_LUI,
            c_OP_AUIPC:  begin w_aop = 3'b110; w_asrc = 1'b1; w_imm = 3'b100; end
            c_OP_SYSTEM: begin w_aop = 3'b111; w_sys = 1'b1; end
            default:     w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: restarts on every state change, counts missed readies
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Capture IR fields in DECODE and latch the cause of each new trap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode  <= 7'd0;
            r_sys_bit <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            if (r_state == S_DECODE) begin
                r_opcode  <= bus.opcode;
                r_sys_bit <= bus.sys_bit;
            end
            if (w_set_cause) begin
                r_cause <= w_cause_next;
            end
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next       = r_state;
        w_set_cause  = 1'b0;
        w_cause_next = r_cause;
        w_dec_en     = 1'b0;
        w_req        = 1'b0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_irw        = 1'b0;
        w_pcw        = 1'b0;
        w_pcs        = 1'b0;
        w_brs        = 1'b0;
        w_rw         = 1'b0;
        w_wb         = 2'b00;
        w_trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                w_rd  = 1'b1;
                if (bus.mem_ready) begin
                    w_irw  = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_set_cause  = 1'b1;
                    w_cause_next = c_CAUSE_BUS;
                    w_next       = S_TRAP;
                end
            end
            S_DECODE: begin
                w_dec_en = 1'b1;
                if (!w_legal) begin
                    w_set_cause  = 1'b1;
                    w_cause_next = c_CAUSE_ILLEGAL;
                    w_next       = S_TRAP;
                end else if (w_sys) begin
                    w_set_cause  = 1'b1;
                    w_cause_next = c_CAUSE_SYSTEM;
                    w_next       = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_dec_en = 1'b1;
                if (w_br) begin
                    w_brs  = 1'b1;
                    w_pcw  = bus.branch_taken;
                    w_pcs  = 1'b1;
                    w_next = S_FETCH;
                end else if (w_load || w_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dec_en = 1'b1;
                w_req    = 1'b1;
                w_rd     = w_load;
                w_wr     = w_store;
                if (bus.mem_ready) begin
                    w_next = w_store ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_set_cause  = 1'b1;
                    w_cause_next = c_CAUSE_BUS;
                    w_next       = S_TRAP;
                end
            end
            S_WB: begin
                w_dec_en = 1'b1;
                w_rw     = 1'b1;
                w_wb     = w_load ? 2'b01 : (w_jump ? 2'b10 : 2'b00);
                w_pcw    = w_jump;
                w_pcs    = w_jump;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                w_trap = 1'b1;
                if ((HALT_ON_EBREAK != 0) && (r_cause == c_CAUSE_SYSTEM) && r_sys_bit) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Drive the bus; every strobe is forced low while reset is asserted
    always_comb begin
        bus.mem_req    = w_req & ~rst;
        bus.mem_read   = w_rd & ~rst;
        bus.mem_write  = w_wr & ~rst;
        bus.ir_write   = w_irw & ~rst;
        bus.pc_write   = w_pcw & ~rst;
        bus.pc_src     = w_pcs & ~rst;
        bus.branch     = w_brs & ~rst;
        bus.reg_write  = w_rw & ~rst;
        bus.wb_sel     = rst ? 2'b00 : w_wb;
        bus.trap       = w_trap & ~rst;
        bus.alu_op     = (w_dec_en && !rst) ? ALUOP_W'(w_aop) : '0;
        bus.alu_src    = w_dec_en & w_asrc & ~rst;
        bus.imm_src    = (w_dec_en && !rst) ? w_imm : 3'b000;
        bus.halted     = (r_state == S_HALT) && !rst;
        bus.trap_cause = r_cause;
        bus.state      = r_state;
    end

endmodule
`default_nettype wire
